// File: rtl/candidate_sweep_engine.sv
// candidate_sweep_engine: LFSR candidate sweeper that buffers checker-satisfying assignments and streams them out
// Ports: clk/rst (async active-high); seed_load/seed reseed the LFSR in IDLE; start/target_cnt/max_tries
// begin a sweep; cand_out/sat_in form the combinational loop through the checker; sol_data/sol_valid/sol_ready
// stream buffered solutions; busy/done/timeout report sweep state; tried_cnt/found_cnt count this sweep.
module candidate_sweep_engine #(
    parameter int WIDTH      = 185,
    parameter int TAP_A      = 184,
    parameter int TAP_B      = 160,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [CNT_W-1:0] max_tries,
    output logic [WIDTH-1:0] cand_out,
    input  logic             sat_in,
    output logic [WIDTH-1:0] sol_data,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] tried_cnt,
    output logic [CNT_W-1:0] found_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic [CNT_W-1:0] tried_q, tried_d, found_q, found_d, tgt_q, tgt_d, max_q, max_d;
    logic             timeout_q, timeout_d;
    logic             full, pop, eval, push, go, hit_tgt, hit_max;
    logic [CNT_W-1:0] tried_inc, found_inc;
    assign sol_valid = wr_q != rd_q;
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop       = sol_valid && sol_ready;
    // A satisfying candidate with nowhere to go holds the sweep; a simultaneous pop frees the slot.
    assign eval      = (state_q == RUN) && !(sat_in && full && !pop);
    assign push      = eval && sat_in;
    assign go        = start && (state_q == IDLE || state_q == DONE);
    assign tried_inc = &tried_q ? tried_q : tried_q + CNT_W'(1);
    assign found_inc = &found_q ? found_q : found_q + CNT_W'(1);
    assign sol_data  = mem_q[rd_q[AW-1:0]];
    assign cand_out  = lfsr_q;
    assign busy      = state_q == RUN || state_q == DRAIN;
    assign done      = state_q == DONE;
    assign timeout   = timeout_q;
    assign tried_cnt = tried_q;
    assign found_cnt = found_q;
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        tried_d   = tried_q;
        found_d   = found_q;
        tgt_d     = tgt_q;
        max_d     = max_q;
        timeout_d = timeout_q;
        hit_tgt   = 1'b0;
        hit_max   = 1'b0;
        if (state_q == IDLE && seed_load) lfsr_d = |seed ? seed : WIDTH'(1);
        if (go) begin
            state_d   = RUN;
            tried_d   = '0;
            found_d   = '0;
            timeout_d = 1'b0;
            tgt_d     = target_cnt;
            max_d     = max_tries;
        end
        if (eval) begin
            tried_d = tried_inc;
            found_d = push ? found_inc : found_q;
            lfsr_d  = {lfsr_q[WIDTH-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};
            // Stop is judged on the updated counts; reaching the target takes precedence over the budget.
            hit_tgt = tgt_q != '0 && found_d == tgt_q;
            hit_max = max_q != '0 && tried_d == max_q;
            if (hit_tgt || hit_max) begin
                state_d   = DRAIN;
                timeout_d = !hit_tgt;
            end
        end
        if (state_q == DRAIN && !sol_valid) state_d = DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= WIDTH'(1);
            wr_q      <= '0;
            rd_q      <= '0;
            tried_q   <= '0;
            found_q   <= '0;
            tgt_q     <= '0;
            max_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            wr_q      <= push ? wr_q + 1'b1 : wr_q;
            rd_q      <= pop ? rd_q + 1'b1 : rd_q;
            tried_q   <= tried_d;
            found_q   <= found_d;
            tgt_q     <= tgt_d;
            max_q     <= max_d;
            timeout_q <= timeout_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= cand_out;
    end
endmodule

// File: tb/tb_candidate_sweep_engine.sv
// tb_candidate_sweep_engine: directed bench for candidate_sweep_engine with a stub checker
module tb_candidate_sweep_engine;
    localparam int W = 185;
    logic          clk = 1'b0, rst = 1'b1, seed_load = 1'b0, start = 1'b0, sol_ready = 1'b0;
    logic [W-1:0]  seed = '0, cand_out, sol_data, c0, x;
    logic [31:0]   target_cnt = '0, max_tries = '0, tried_cnt, found_cnt;
    logic          sat_in, sol_valid, busy, done, timeout;
    logic          saw_valid = 1'b0;
    int            mode = 0, n_chk = 0, n_fail = 0, tries;
    logic [W-1:0]  got_q[$], exp_q[$];

    candidate_sweep_engine dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
        .target_cnt(target_cnt), .max_tries(max_tries), .cand_out(cand_out), .sat_in(sat_in),
        .sol_data(sol_data), .sol_valid(sol_valid), .sol_ready(sol_ready), .busy(busy),
        .done(done), .timeout(timeout), .tried_cnt(tried_cnt), .found_cnt(found_cnt)
    );

    always #5 clk = ~clk;
    // stub checker: mode 0 -> odd candidates, 1 -> never, 2 -> always
    assign sat_in = (mode == 0) ? cand_out[0] : (mode == 2);

    always @(negedge clk) begin
        if (sol_valid) saw_valid = 1'b1;
        if (sol_valid && sol_ready) got_q.push_back(sol_data);
    end

    function automatic logic [W-1:0] nx(input logic [W-1:0] v);
        return {v[W-2:0], v[184] ^ v[160]};
    endfunction

    function automatic logic [W-1:0] adv(input logic [W-1:0] v, input int n);
        logic [W-1:0] r = v;
        for (int i = 0; i < n; i++) r = nx(r);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("wait_done", done, 1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_cand", cand_out, 1);
        chk("rst_valid", sol_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_tried", tried_cnt, 0);
        chk("rst_found", found_cnt, 0);

        // odd-candidate sweep, target 3, unlimited tries
        mode = 0; sol_ready = 1'b1; target_cnt = 3; max_tries = 0;
        x = 1; tries = 0;
        while (exp_q.size() < 3) begin
            tries++;
            if (x[0]) exp_q.push_back(x);
            x = nx(x);
        end
        pulse_start();
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_lat_valid", sol_valid, 1);
        chk("t1_lat_data", sol_data, 1);
        wait_done(2000);
        chk("t1_nsol", got_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t1_sol%0d", i), got_q[i], exp_q[i]);
        chk("t1_found", found_cnt, 3);
        chk("t1_tried", tried_cnt, tries);
        chk("t1_timeout", timeout, 0);
        chk("t1_lfsr_hold", cand_out, x);

        // never-satisfied sweep with budget 10; start/seed_load mid-run ignored
        mode = 1; max_tries = 10; target_cnt = 0; saw_valid = 1'b0; c0 = cand_out;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1; seed_load = 1'b1; seed = 'h123; max_tries = 3; target_cnt = 1;
        tick();
        start = 1'b0; seed_load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t2_tried9", tried_cnt, 9);
        tick();
        chk("t2_tried10", tried_cnt, 10);
        chk("t2_drain_busy", busy, 1);
        chk("t2_not_done", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_timeout", timeout, 1);
        chk("t2_found", found_cnt, 0);
        chk("t2_no_valid", saw_valid, 0);
        chk("t2_lfsr", cand_out, adv(c0, 10));

        // always-satisfied with blocked consumer: fill, stall, then resume
        mode = 2; sol_ready = 1'b0; target_cnt = 6; max_tries = 0; got_q.delete(); c0 = cand_out;
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        chk("t3_stall_tried", tried_cnt, 4);
        chk("t3_stall_found", found_cnt, 4);
        chk("t3_stall_lfsr", cand_out, adv(c0, 4));
        chk("t3_stall_valid", sol_valid, 1);
        chk("t3_stall_busy", busy, 1);
        sol_ready = 1'b1;
        wait_done(100);
        chk("t3_nsol", got_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_sol%0d", i), got_q[i], adv(c0, i));
        chk("t3_found", found_cnt, 6);
        chk("t3_tried", tried_cnt, 6);
        chk("t3_timeout", timeout, 0);

        // target and budget reached on the same try
        target_cnt = 5; max_tries = 5; got_q.delete();
        pulse_start();
        wait_done(100);
        chk("t4_timeout", timeout, 0);
        chk("t4_found", found_cnt, 5);
        chk("t4_tried", tried_cnt, 5);
        chk("t4_nsol", got_q.size(), 5);

        // reseed in IDLE, then abort a sweep with buffered solutions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_idle_done", done, 0);
        chk("t5_idle_cand", cand_out, 1);
        seed_load = 1'b1; seed = '0;
        tick();
        chk("t5_seed0", cand_out, 1);
        seed = 'h5a5a;
        tick();
        seed_load = 1'b0;
        chk("t5_seed", cand_out, 'h5a5a);
        sol_ready = 1'b0; target_cnt = 0; max_tries = 0;
        pulse_start();
        tick();
        tick();
        chk("t5_buffered", found_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", sol_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_tried", tried_cnt, 0);
        chk("t5_rst_found", found_cnt, 0);
        chk("t5_rst_cand", cand_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
